cmp_result_filter: RTL and testbench

//   Downstream consumer of the 2-bit magnitude comparator. Samples its

---
 rtl/cmp_result_filter.sv | 147 ++++++++++++++
 tb/tb_cmp_result_filter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_result_filter.sv
// Debounce filter for a 3-wire less/equal/greater comparator result.
// Accepts a legal one-hot code once it is stable for STABLE_CNT samples.
module cmp_result_filter #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    input  logic             clr,
    output logic             res_less,
    output logic             res_equal,
    output logic             res_greater,
    output logic             res_vld,
    output logic             err,
    output logic [CNT_W-1:0] cnt_less,
    output logic [CNT_W-1:0] cnt_equal,
    output logic [CNT_W-1:0] cnt_greater
);

    localparam int CW = (STABLE_CNT > 2) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] LOCK  = 2'd2;

    logic [2:0]       in_q;
    logic [1:0]       state_q, state_d;
    logic [2:0]       cand_q, cand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       res_q, res_d;
    logic             vld_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cl_q, cl_d;
    logic [CNT_W-1:0] ce_q, ce_d;
    logic [CNT_W-1:0] cg_q, cg_d;
    logic             legal;
    logic             accept;
    logic             ill;

    assign legal = (in_q == 3'b001) || (in_q == 3'b010) || (in_q == 3'b100);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        ill     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (legal) begin
                    cand_d  = in_q;
                    cnt_d   = ONE;
                    state_d = CHECK;
                end else begin
                    ill = 1'b1;
                end
            end
            CHECK: begin
                if (!legal) begin
                    ill     = 1'b1;
                    state_d = IDLE;
                end else if (in_q == cand_q) begin
                    if (cnt_q >= LAST) begin
                        accept  = 1'b1;
                        state_d = LOCK;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    cand_d = in_q;
                    cnt_d  = ONE;
                end
            end
            LOCK: begin
                if (!legal) begin
                    ill     = 1'b1;
                    state_d = IDLE;
                end else if (in_q != res_q) begin
                    cand_d  = in_q;
                    cnt_d   = ONE;
                    state_d = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clr beats an increment, but a new illegal sample beats clr on err
    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] c,
        input logic             hit,
        input logic             wipe
    );
        if (wipe)
            return '0;
        if (hit && (c != {CNT_W{1'b1}}))
            return c + 1'b1;
        return c;
    endfunction

    assign res_d = accept ? cand_q : res_q;
    assign err_d = ill ? 1'b1 : (clr ? 1'b0 : err_q);
    assign cl_d  = bump(cl_q, accept && cand_q[0], clr);
    assign ce_d  = bump(ce_q, accept && cand_q[1], clr);
    assign cg_d  = bump(cg_q, accept && cand_q[2], clr);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            in_q    <= 3'b000;
            state_q <= IDLE;
            cand_q  <= 3'b000;
            cnt_q   <= '0;
            res_q   <= 3'b000;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cl_q    <= '0;
            ce_q    <= '0;
            cg_q    <= '0;
        end else begin
            in_q    <= {greater, equal, less};
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            vld_q   <= accept;
            err_q   <= err_d;
            cl_q    <= cl_d;
            ce_q    <= ce_d;
            cg_q    <= cg_d;
        end
    end

    assign res_less    = res_q[0];
    assign res_equal   = res_q[1];
    assign res_greater = res_q[2];
    assign res_vld     = vld_q;
    assign err         = err_q;
    assign cnt_less    = cl_q;
    assign cnt_equal   = ce_q;
    assign cnt_greater = cg_q;

endmodule

// File: tb/tb_cmp_result_filter.sv
// Bench for cmp_result_filter: default instance plus a CNT_W=2 instance
// sharing the same stimulus for the saturation checks.
module tb_cmp_result_filter;

    typedef struct {
        logic [2:0] in;
        logic       clr;
        logic [2:0] res;
        logic       vld;
        logic       err;
        logic [7:0] cl;
        logic [7:0] ce;
        logic [7:0] cg;
    } vec_t;

    localparam logic [2:0] L = 3'b001;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] X = 3'b011;
    localparam logic [2:0] Z = 3'b000;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       less, equal, greater, clr;

    logic       res_less, res_equal, res_greater, res_vld, err;
    logic [7:0] cnt_less, cnt_equal, cnt_greater;
    logic       s_res_less, s_res_equal, s_res_greater, s_res_vld, s_err;
    logic [1:0] s_cnt_less, s_cnt_equal, s_cnt_greater;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    cmp_result_filter dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .less        (less),
        .equal       (equal),
        .greater     (greater),
        .clr         (clr),
        .res_less    (res_less),
        .res_equal   (res_equal),
        .res_greater (res_greater),
        .res_vld     (res_vld),
        .err         (err),
        .cnt_less    (cnt_less),
        .cnt_equal   (cnt_equal),
        .cnt_greater (cnt_greater)
    );

    cmp_result_filter #(.STABLE_CNT(4), .CNT_W(2)) dut_sat (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .less        (less),
        .equal       (equal),
        .greater     (greater),
        .clr         (clr),
        .res_less    (s_res_less),
        .res_equal   (s_res_equal),
        .res_greater (s_res_greater),
        .res_vld     (s_res_vld),
        .err         (s_err),
        .cnt_less    (s_cnt_less),
        .cnt_equal   (s_cnt_equal),
        .cnt_greater (s_cnt_greater)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic c);
        less    = v[0];
        equal   = v[1];
        greater = v[2];
        clr     = c;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [2:0] res_m();
        return {res_greater, res_equal, res_less};
    endfunction

    function automatic logic [2:0] res_s();
        return {s_res_greater, s_res_equal, s_res_less};
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, "_res"}, 0, 32'(res_m()), 0);
        chk({nm, "_vld"}, 0, 32'(res_vld), 0);
        chk({nm, "_err"}, 0, 32'(err), 0);
        chk({nm, "_cnts"}, 0, {8'd0, cnt_less, cnt_equal, cnt_greater}, 0);
        chk({nm, "_sat_all"}, 0,
            {17'd0, res_s(), s_res_vld, s_err,
             s_cnt_less, s_cnt_equal, s_cnt_greater}, 0);
    endtask

    task automatic add(input logic [2:0] in, input logic c,
                       input logic [2:0] res, input logic vld,
                       input logic e, input int cl, input int ce,
                       input int cg);
        vec_t v;
        v.in  = in;
        v.clr = c;
        v.res = res;
        v.vld = vld;
        v.err = e;
        v.cl  = 8'(cl);
        v.ce  = 8'(ce);
        v.cg  = 8'(cg);
        vecs.push_back(v);
    endtask

    initial begin
        // first edge after reset samples the reset value 000 -> err
        add(L, 0, Z, 0, 1, 0, 0, 0);
        add(L, 0, Z, 0, 1, 0, 0, 0);
        add(L, 1, Z, 0, 0, 0, 0, 0);
        add(L, 0, Z, 0, 0, 0, 0, 0);
        add(L, 0, L, 1, 0, 1, 0, 0);
        add(L, 0, L, 0, 0, 1, 0, 0);
        add(L, 0, L, 0, 0, 1, 0, 0);
        add(E, 0, L, 0, 0, 1, 0, 0);
        add(E, 0, L, 0, 0, 1, 0, 0);
        add(L, 0, L, 0, 0, 1, 0, 0);
        add(L, 0, L, 0, 0, 1, 0, 0);
        add(L, 0, L, 0, 0, 1, 0, 0);
        add(L, 0, L, 0, 0, 1, 0, 0);
        add(L, 0, L, 1, 0, 2, 0, 0);
        add(L, 0, L, 0, 0, 2, 0, 0);
        add(X, 0, L, 0, 0, 2, 0, 0);
        add(L, 0, L, 0, 1, 2, 0, 0);
        add(L, 0, L, 0, 1, 2, 0, 0);
        add(L, 0, L, 0, 1, 2, 0, 0);
        add(L, 0, L, 0, 1, 2, 0, 0);
        add(L, 0, L, 1, 1, 3, 0, 0);
        add(G, 0, L, 0, 1, 3, 0, 0);
        add(G, 1, L, 0, 0, 0, 0, 0);
        add(G, 0, L, 0, 0, 0, 0, 0);
        add(G, 0, L, 0, 0, 0, 0, 0);
        add(G, 1, G, 1, 0, 0, 0, 0);
        add(G, 0, G, 0, 0, 0, 0, 0);
        add(Z, 0, G, 0, 0, 0, 0, 0);
        add(G, 1, G, 0, 1, 0, 0, 0);
        add(G, 0, G, 0, 1, 0, 0, 0);
        add(G, 0, G, 0, 1, 0, 0, 0);
        add(G, 0, G, 0, 1, 0, 0, 0);
        add(G, 0, G, 1, 1, 0, 0, 1);

        sys_rst = 1'b1;
        drive(Z, 1'b0);
        #2;
        chk_zero("por");
        #10;
        sys_rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].in, vecs[i].clr);
            step();
            chk("tbl_res", i, 32'(res_m()), 32'(vecs[i].res));
            chk("tbl_vld", i, 32'(res_vld), 32'(vecs[i].vld));
            chk("tbl_err", i, 32'(err), 32'(vecs[i].err));
            chk("tbl_cnt", i, {8'd0, cnt_less, cnt_equal, cnt_greater},
                {8'd0, vecs[i].cl, vecs[i].ce, vecs[i].cg});
        end

        // async reset while locked: outputs clear before any edge
        sys_rst = 1'b1;
        #1;
        chk_zero("rst_lock");
        #1;
        sys_rst = 1'b0;
        drive(L, 1'b0);

        // reset mid-CHECK: candidate discarded, full window needed again
        repeat (3) step();
        sys_rst = 1'b1;
        #1;
        chk_zero("rst_chk");
        #1;
        sys_rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("rchk_vld", k, 32'(res_vld), (k == 5) ? 1 : 0);
        end
        chk("rchk_res", 0, 32'(res_m()), 32'(L));
        chk("rchk_cl", 0, 32'(cnt_less), 1);

        // alternate G/L, five accepts each
        for (int s = 0; s < 10; s++) begin
            drive(((s % 2) == 0) ? G : L, 1'b0);
            for (int k = 1; k <= 5; k++) begin
                step();
                if (k == 5) begin
                    chk("sat_vld", s, 32'(s_res_vld), 1);
                    chk("sat_res", s, 32'(res_s()),
                        32'(((s % 2) == 0) ? G : L));
                end
            end
        end
        chk("sat_cl", 0, 32'(s_cnt_less), 3);
        chk("sat_cg", 0, 32'(s_cnt_greater), 3);
        chk("sat_ce", 0, 32'(s_cnt_equal), 0);
        chk("main_cl", 0, 32'(cnt_less), 6);
        chk("main_cg", 0, 32'(cnt_greater), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
